// File: rtl/bch_pkg.sv
// ---------------------------------------------------------------------------
// bch_pkg
// Shared definitions for the serial BCH encoder: the encoder FSM state type
// and the default code parameters (BCH(15,7), g(x) = x^8+x^7+x^6+x^4+1).
// No ports; imported by bch_lfsr and bch_encoder_param.
// ---------------------------------------------------------------------------
package bch_pkg;

   // Encoder phases: accepting message bits, then streaming out parity.
   typedef enum logic {
      ST_MSG = 1'b0,
      ST_PAR = 1'b1
   } bch_state_t;

   // Default code: 7 message bits, 8 parity bits, generator without x^P term.
   localparam int         DEF_K        = 7;
   localparam int         DEF_P        = 8;
   localparam logic [7:0] DEF_GEN_POLY = 8'hD1;

endpackage

// File: rtl/bch_lfsr.sv
// ---------------------------------------------------------------------------
// bch_lfsr
// Division LFSR that accumulates the remainder of m(x)*x^P mod g(x), one
// message bit per shift. The register also serves as the parallel parity
// view, so it is never shifted during parity output; a select index picks
// the bit to serialise instead.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset, clears the register
//   i_shift  advance the LFSR by one message bit (i_din)
//   i_clear  clear the register; combined with i_shift the step starts from 0
//   i_din    message bit fed into the divider
//   i_sel    bit index driven onto o_sout
//   o_r      remainder register (parallel parity)
//   o_sout   o_r[i_sel]
// ---------------------------------------------------------------------------
module bch_lfsr
   import bch_pkg::*;
#(
   parameter int           P        = DEF_P,
   parameter logic [P-1:0] GEN_POLY = P'(DEF_GEN_POLY)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_shift,
   input  logic                 i_clear,
   input  logic                 i_din,
   input  logic [$clog2(P)-1:0] i_sel,
   output logic [P-1:0]         o_r,
   output logic                 o_sout
);

   logic [P-1:0] base;
   logic [P-1:0] nxt;
   logic         fb;

   // Next-state of the divider. When a clear coincides with a shift the
   // step is taken from an all-zero register, so the first bit of a new
   // message never sees the previous remainder.
   always_comb begin
      base = i_clear ? '0 : o_r;
      fb   = i_din ^ base[P-1];
      nxt  = {base[P-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);
   end

   // Remainder register: shift has priority, a lone clear zeroes it,
   // otherwise the remainder is held for the parallel parity view.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_r <= '0;
      end else if (i_shift) begin
         o_r <= nxt;
      end else if (i_clear) begin
         o_r <= '0;
      end
   end

   assign o_sout = o_r[i_sel];

endmodule

// File: rtl/bch_encoder_param.sv
// ---------------------------------------------------------------------------
// bch_encoder_param
// Serial systematic BCH encoder. K message bits are accepted MSB first and
// echoed on o_cw one cycle later; the P parity bits (MSB first) follow
// immediately, giving K+P consecutive valid codeword bits per message.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_m       message bit, MSB first
//   i_dv      i_m valid; accepted when i_dv && o_ready
//   i_abort   synchronous abort of the current codeword (beats i_dv)
//   o_ready   high while message bits can be accepted
//   o_cw      serial codeword bit
//   o_cw_vld  o_cw valid
//   o_parity  remainder register, parallel view
//   o_done    one-cycle pulse when o_parity first holds the final remainder
// ---------------------------------------------------------------------------
module bch_encoder_param
   import bch_pkg::*;
#(
   parameter int           K        = DEF_K,
   parameter int           P        = DEF_P,
   parameter logic [P-1:0] GEN_POLY = P'(DEF_GEN_POLY)
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_m,
   input  logic         i_dv,
   input  logic         i_abort,
   output logic         o_ready,
   output logic         o_cw,
   output logic         o_cw_vld,
   output logic [P-1:0] o_parity,
   output logic         o_done
);

   localparam int W  = $clog2(K + P) + 1;
   localparam int SW = $clog2(P);

   localparam logic [W-1:0] K_LAST  = W'(K - 1);
   localparam logic [W-1:0] PAR_END = W'(K + P);
   localparam logic [W-1:0] SEL_TOP = W'(K + P - 1);

   bch_state_t    state;
   logic [W-1:0]  cnt;
   logic          accept;
   logic          lfsr_clear;
   logic [W-1:0]  sel_full;
   logic [SW-1:0] sel;
   logic          par_bit;

   // The counter keeps running through the parity phase (K .. K+P), so the
   // parity bit to emit is simply (K+P-1) - cnt, i.e. P-1 down to 0.
   always_comb begin
      accept     = (state == ST_MSG) && i_dv && !i_abort;
      lfsr_clear = i_abort || (accept && (cnt == '0));
      sel_full   = SEL_TOP - cnt;
      sel        = sel_full[SW-1:0];
   end

   assign o_ready = (state == ST_MSG);

   bch_lfsr #(
      .P        (P),
      .GEN_POLY (GEN_POLY)
   ) u_lfsr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_shift (accept),
      .i_clear (lfsr_clear),
      .i_din   (i_m),
      .i_sel   (sel),
      .o_r     (o_parity),
      .o_sout  (par_bit)
   );

   // Encoder FSM with registered codeword outputs. In MSG every accepted bit
   // is echoed; the K-th one moves to PAR and raises o_done together with
   // the final LFSR update. PAR emits one parity bit per cycle, then spends
   // one cycle dropping o_cw_vld before handing back to MSG.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= ST_MSG;
         cnt      <= '0;
         o_cw     <= 1'b0;
         o_cw_vld <= 1'b0;
         o_done   <= 1'b0;
      end else if (i_abort) begin
         state    <= ST_MSG;
         cnt      <= '0;
         o_cw     <= 1'b0;
         o_cw_vld <= 1'b0;
         o_done   <= 1'b0;
      end else begin
         case (state)
            ST_MSG: begin
               o_done <= 1'b0;
               if (i_dv) begin
                  o_cw     <= i_m;
                  o_cw_vld <= 1'b1;
                  cnt      <= cnt + 1'b1;
                  if (cnt == K_LAST) begin
                     state  <= ST_PAR;
                     o_done <= 1'b1;
                  end
               end else begin
                  o_cw_vld <= 1'b0;
               end
            end
            ST_PAR: begin
               o_done <= 1'b0;
               if (cnt != PAR_END) begin
                  o_cw     <= par_bit;
                  o_cw_vld <= 1'b1;
                  cnt      <= cnt + 1'b1;
               end else begin
                  o_cw_vld <= 1'b0;
                  cnt      <= '0;
                  state    <= ST_MSG;
               end
            end
            default: begin
               state    <= ST_MSG;
               cnt      <= '0;
               o_cw_vld <= 1'b0;
               o_done   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bch_encoder_param.sv
// ---------------------------------------------------------------------------
// tb_bch_encoder_param
// Directed bench for bch_encoder_param with default BCH(15,7) parameters.
// Expected parities are hand-computed from g(x) = x^8+x^7+x^6+x^4+1.
// ---------------------------------------------------------------------------
module tb_bch_encoder_param;

   localparam int K = 7;
   localparam int P = 8;
   localparam int N = K + P;

   logic         i_clk   = 1'b0;
   logic         i_rst_n = 1'b1;
   logic         i_m     = 1'b0;
   logic         i_dv    = 1'b0;
   logic         i_abort = 1'b0;
   logic         o_ready;
   logic         o_cw;
   logic         o_cw_vld;
   logic [P-1:0] o_parity;
   logic         o_done;

   int n_vec = 0;
   int n_bad = 0;

   logic [N-1:0] cw_bits;
   int           cw_cnt;
   int           done_cnt;
   logic [P-1:0] done_par;
   int           par_left;
   int           gap_cnt;

   bch_encoder_param #(
      .K        (K),
      .P        (P),
      .GEN_POLY (8'hD1)
   ) dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_m      (i_m),
      .i_dv     (i_dv),
      .i_abort  (i_abort),
      .o_ready  (o_ready),
      .o_cw     (o_cw),
      .o_cw_vld (o_cw_vld),
      .o_parity (o_parity),
      .o_done   (o_done)
   );

   // Free-running 10 ns clock.
   always #5 i_clk = ~i_clk;

   // Safety net so a stuck run still ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Codeword monitor, sampled on the falling edge: collects valid bits,
   // counts o_done pulses, captures the parity seen at o_done and counts
   // any idle cycle within the P cycles that must follow o_done.
   always @(negedge i_clk) begin
      if (par_left > 0) begin
         if (!o_cw_vld) gap_cnt = gap_cnt + 1;
         par_left = par_left - 1;
      end
      if (o_cw_vld) begin
         cw_bits = {cw_bits[N-2:0], o_cw};
         cw_cnt  = cw_cnt + 1;
      end
      if (o_done) begin
         done_cnt = done_cnt + 1;
         done_par = o_parity;
         par_left = P;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_vec = n_vec + 1;
      if (actual !== expected) begin
         n_bad = n_bad + 1;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic clearMon();
      cw_bits  = '0;
      cw_cnt   = 0;
      done_cnt = 0;
      done_par = '0;
      par_left = 0;
      gap_cnt  = 0;
   endtask

   // Feed K bits MSB first; optional one-cycle gap between bits. Returns in
   // the cycle right after the K-th bit was accepted.
   task automatic sendBits(input logic [K-1:0] msg, input bit toggle);
      for (int i = K - 1; i >= 0; i--) begin
         i_m  = msg[i];
         i_dv = 1'b1;
         @(posedge i_clk); #1;
         if (toggle && i > 0) begin
            i_dv = 1'b0;
            @(posedge i_clk); #1;
         end
      end
   endtask

   // Encode one message and check parity, codeword stream and ready timing.
   task automatic applyStimulus(input string name, input logic [K-1:0] msg,
                                input logic [P-1:0] exp_par, input bit toggle,
                                input bit hold_dv);
      clearMon();
      sendBits(msg, toggle);
      i_dv = hold_dv;
      repeat (P) @(posedge i_clk);
      #1;
      checkOutput({name, "_ready_lo"}, {31'd0, o_ready}, 32'd0);
      @(posedge i_clk); #1;
      checkOutput({name, "_ready_hi"}, {31'd0, o_ready}, 32'd1);
      i_dv = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      checkOutput({name, "_done_cnt"}, done_cnt, 1);
      checkOutput({name, "_done_par"}, {24'd0, done_par}, {24'd0, exp_par});
      checkOutput({name, "_par_hold"}, {24'd0, o_parity}, {24'd0, exp_par});
      checkOutput({name, "_cw_cnt"}, cw_cnt, N);
      checkOutput({name, "_cw_bits"}, {17'd0, cw_bits}, {17'd0, msg, exp_par});
      checkOutput({name, "_par_gaps"}, gap_cnt, 0);
   endtask

   initial begin
      clearMon();
      $display("[TB] start");
      #1 i_rst_n = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      checkOutput("rst_parity", {24'd0, o_parity}, 32'd0);
      checkOutput("rst_cw", {31'd0, o_cw}, 32'd0);
      checkOutput("rst_cw_vld", {31'd0, o_cw_vld}, 32'd0);
      checkOutput("rst_done", {31'd0, o_done}, 32'd0);
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      checkOutput("rst_ready", {31'd0, o_ready}, 32'd1);

      applyStimulus("zero", 7'b0000000, 8'h00, 1'b0, 1'b0);
      applyStimulus("one", 7'b0000001, 8'hD1, 1'b0, 1'b0);
      applyStimulus("toggle", 7'b0000011, 8'hA2, 1'b1, 1'b0);
      applyStimulus("ones", 7'b1111111, 8'hFF, 1'b0, 1'b0);
      applyStimulus("dv_hold", 7'b1111111, 8'hFF, 1'b0, 1'b1);

      // Abort after four bits, with i_dv also high on the abort cycle.
      clearMon();
      for (int i = 0; i < 4; i++) begin
         i_m  = 1'b1;
         i_dv = 1'b1;
         @(posedge i_clk); #1;
      end
      i_abort = 1'b1;
      @(posedge i_clk); #1;
      checkOutput("abort_cw_vld", {31'd0, o_cw_vld}, 32'd0);
      checkOutput("abort_done", {31'd0, o_done}, 32'd0);
      checkOutput("abort_parity", {24'd0, o_parity}, 32'd0);
      i_abort = 1'b0;
      i_dv    = 1'b0;
      @(posedge i_clk); #1;
      applyStimulus("post_abort", 7'b0000001, 8'hD1, 1'b0, 1'b0);

      // Reset in the middle of the parity section.
      clearMon();
      sendBits(7'b1111111, 1'b0);
      i_dv = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      i_rst_n = 1'b0;
      #1;
      checkOutput("midrst_parity", {24'd0, o_parity}, 32'd0);
      checkOutput("midrst_cw", {31'd0, o_cw}, 32'd0);
      checkOutput("midrst_cw_vld", {31'd0, o_cw_vld}, 32'd0);
      checkOutput("midrst_done", {31'd0, o_done}, 32'd0);
      clearMon();
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      repeat (20) @(posedge i_clk);
      #1;
      checkOutput("midrst_no_done", done_cnt, 0);
      checkOutput("midrst_no_cw", cw_cnt, 0);
      checkOutput("midrst_ready", {31'd0, o_ready}, 32'd1);
      applyStimulus("post_rst", 7'b0000011, 8'hA2, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/bch_encoder_param.md
BCH_ENCODER_PARAM -- requirements
Module: bch_encoder_param

Interface
REQ-001 SHALL have parameter K, default 7: message length in bits (K >= 1).
REQ-002 SHALL have parameter P, default 8: parity length in bits (P >= 2).
REQ-003 SHALL have parameter GEN_POLY, P bits wide, default 8'hD1: generator coefficients g[P-1:0], with implicit x^P term (default g(x)=x^8+x^7+x^6+x^4+1, BCH(15,7)).
REQ-004 SHALL have port i_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port i_m, input, 1: message bit, MSB first.
REQ-007 SHALL have port i_dv, input, 1: i_m valid; a bit is accepted when i_dv && o_ready.
REQ-008 SHALL have port i_abort, input, 1: synchronous abort of the current codeword.
REQ-009 SHALL have port o_ready, output, 1: block can accept a message bit.
REQ-010 SHALL have port o_cw, output, 1: serial systematic codeword bit.
REQ-011 SHALL have port o_cw_vld, output, 1: o_cw valid this cycle.
REQ-012 SHALL have port o_parity, output, P: parity register, parallel view.
REQ-013 SHALL have port o_done, output, 1: one-cycle pulse, parity complete.

Function
REQ-014 SHALL implement FSM states MSG and PAR; reset state MSG.
REQ-015 SHALL, in MSG, drive o_ready=1 and hold all state when i_dv=0 (gaps allowed, any length).
REQ-016 SHALL, per accepted bit, update the LFSR as: fb = i_m ^ r[P-1]; r <= {r[P-2:0],1'b0} ^ (fb ? GEN_POLY : 0).
REQ-017 SHALL register each accepted bit to o_cw with o_cw_vld=1 on the next cycle (1-cycle latency).
REQ-018 SHALL count accepted bits with a counter of width $clog2(K+P)+1; on the K-th accepted bit go to PAR.
REQ-019 SHALL assert o_done for exactly the one cycle in which o_parity first holds the final remainder, i.e. the cycle after the K-th bit is accepted.
REQ-020 SHALL hold o_parity stable from o_done until the first bit of the next message is accepted.
REQ-021 SHALL, in PAR, drive o_ready=0, ignore i_dv/i_m, and emit r[P-1] down to r[0] on o_cw with o_cw_vld=1 for P consecutive cycles, directly following the K-th message bit on o_cw.
REQ-022 SHALL return to MSG after the P-th parity bit and clear the LFSR when the first bit of the next message is accepted; o_ready is 1 again in the cycle after the last parity bit is output.
REQ-023 SHALL, on i_abort=1 in any state, clear counter and LFSR, go to MSG, and drive o_cw_vld=0 and o_done=0 next cycle; i_abort takes priority over a simultaneous i_dv.
REQ-024 SHALL produce a total codeword of exactly K+P valid o_cw bits per message with no idle cycles inside the parity section.

Reset
REQ-025 SHALL, on i_rst_n=0, asynchronously set state=MSG, counter=0, LFSR=0, o_parity=0, o_cw=0, o_cw_vld=0, o_done=0; o_ready=1 once i_rst_n is released.
REQ-026 SHALL discard any partial codeword on reset mid-message or mid-parity, with no o_done afterwards.

Structure
REQ-027 SHALL place the FSM state enum and default K/P/GEN_POLY constants in shared package bch_pkg.
REQ-028 SHALL contain one sub-module, bch_lfsr (parameters P, GEN_POLY; shift, clear and serial-out controls).

Verification
REQ-029 SHALL test default params with message 7'b0000000 -> o_parity=8'h00, 15 o_cw bits all 0, one o_done pulse.
REQ-030 SHALL test message 7'b0000001 -> o_parity=8'hD1; o_cw sequence 0000001 then 11010001.
REQ-031 SHALL test message 7'b0000011 with i_dv toggling 1/0 every cycle -> o_parity=8'hA2; o_done exactly once.
REQ-032 SHALL test i_abort after 4 bits, then message 7'b0000001 -> o_parity=8'hD1 (no residue from the aborted message).
REQ-033 SHALL test i_rst_n pulse mid-parity -> all outputs 0 immediately, then the next message encodes correctly.
REQ-034 SHALL test i_dv held 1 throughout PAR -> exactly K+P o_cw_vld cycles, with no extra bits accepted.
